candidate_generator: RTL and testbench

Upstream password-candidate source for the MD5 search datapath. Enumerates lowercase strings in bijective base-26 order ("a".."z", "aa".."zz", ...) from a programmable start index with a programmable stride, so several search cores can interleave. Each candidate is packed left-justified into a 128-bit word with its byte length and offered over a valid/ready handshake to the controller that feeds the MD5 core.

---
 rtl/candidate_generator_pkg.sv | 29 ++
 rtl/candidate_generator_if.sv | 33 +++
 rtl/candidate_generator_odometer.sv | 70 +++++++
 rtl/candidate_generator.sv | 181 ++++++++++++++++++
 tb/tb_candidate_generator.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/candidate_generator_pkg.sv
// ---------------------------------------------------------------------------
// candidate_generator_pkg
// Shared definitions for the password-candidate generator:
//   - controller state encoding
//   - default alphabet (lowercase ASCII, 26 symbols) and maximum length
//   - candidate word width (16 bytes, left-justified)
//   - eff_stride(): maps a programmed stride of 0 onto 1
// ---------------------------------------------------------------------------
package candidate_generator_pkg;

  localparam int         WORD_W        = 128;
  localparam int         DIGIT_W       = 8;
  localparam int         MAX_LEN_DEF   = 16;
  localparam logic [7:0] CHAR_BASE_DEF = 8'h61;
  localparam int         RADIX_DEF     = 26;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_OFFER = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A stride of zero would stall the odometer forever, so it behaves as 1.
  function automatic logic [2:0] eff_stride(input logic [2:0] s);
    return (s == 3'd0) ? 3'd1 : s;
  endfunction

endpackage

// File: rtl/candidate_generator_if.sv
// ---------------------------------------------------------------------------
// candidate_generator_if
// Control and candidate handshake bundle of the generator.
//   master (generator): drives guess_valid, guess, guess_len, exhausted,
//                       busy, issued_count; receives enable, start_index,
//                       stride, stop, guess_ready
//   slave  (consumer) : the mirror image
// ---------------------------------------------------------------------------
interface candidate_generator_if;
  import candidate_generator_pkg::*;

  logic              enable;
  logic [7:0]        start_index;
  logic [2:0]        stride;
  logic              stop;
  logic              guess_ready;
  logic              guess_valid;
  logic [WORD_W-1:0] guess;
  logic [7:0]        guess_len;
  logic              exhausted;
  logic              busy;
  logic [31:0]       issued_count;

  modport master (
    input  enable, start_index, stride, stop, guess_ready,
    output guess_valid, guess, guess_len, exhausted, busy, issued_count
  );

  modport slave (
    output enable, start_index, stride, stop, guess_ready,
    input  guess_valid, guess, guess_len, exhausted, busy, issued_count
  );
endinterface

// File: rtl/candidate_generator_odometer.sv
// ---------------------------------------------------------------------------
// candidate_generator_odometer
// Combinational bijective-base-RADIX adder for the candidate odometer.
//   i_digits   : digit i is character i (digit 0 = most significant)
//   i_len      : current length L (1..MAX_LEN); digit L-1 is least significant
//   i_step     : amount to add (1..7)
//   o_digits   : digits after the add
//   o_len      : length after the add (L+1 when a new leading digit appears)
//   o_overflow : carry out of digit 0 while already at MAX_LEN
// Each digit position absorbs at most one wrap (carry 0 or 1), which is
// exact whenever RADIX exceeds the largest step.
// ---------------------------------------------------------------------------
module candidate_generator_odometer #(
  parameter int MAX_LEN = 16,
  parameter int RADIX   = 26
) (
  input  logic [MAX_LEN-1:0][7:0] i_digits,
  input  logic [7:0]              i_len,
  input  logic [2:0]              i_step,
  output logic [MAX_LEN-1:0][7:0] o_digits,
  output logic [7:0]              o_len,
  output logic                    o_overflow
);

  logic [MAX_LEN-1:0][7:0] w_added;
  logic [8:0]              w_carry_out;

  // Ripple from the least significant live digit toward digit 0; positions
  // at or beyond L are unused and pass through untouched (they hold zero).
  always_comb begin
    logic [8:0] carry;
    logic [8:0] sum;
    w_added = i_digits;
    carry   = {6'd0, i_step};
    sum     = 9'd0;
    for (int i = MAX_LEN - 1; i >= 0; i--) begin
      if (i < int'(i_len)) begin
        sum = {1'b0, i_digits[i]} + carry;
        if (sum >= 9'(RADIX)) begin
          w_added[i] = 8'(sum - 9'(RADIX));
          carry      = 9'd1;
        end else begin
          w_added[i] = sum[7:0];
          carry      = 9'd0;
        end
      end
    end
    w_carry_out = carry;
  end

  // A carry out of digit 0 grows the string by a new leading digit of value
  // 0 (bijective numbering), shifting every existing digit one place right.
  always_comb begin
    o_digits   = w_added;
    o_len      = i_len;
    o_overflow = 1'b0;
    if (w_carry_out != 9'd0) begin
      if (int'(i_len) >= MAX_LEN) begin
        o_overflow = 1'b1;
      end else begin
        o_len       = i_len + 8'd1;
        o_digits[0] = 8'd0;
        for (int j = 1; j < MAX_LEN; j++) begin
          o_digits[j] = w_added[j-1];
        end
      end
    end
  end

endmodule

// File: rtl/candidate_generator.sv
// ---------------------------------------------------------------------------
// candidate_generator
// Enumerates candidate strings in bijective base-RADIX order starting at a
// programmable index and advancing by a programmable stride, offering each
// one over a valid/ready handshake.
//   i_clock : system clock, rising edge
//   i_reset : asynchronous active-high reset
//   io_bus  : candidate_generator_if.master
//             enable       run gate (low freezes everything, drops valid)
//             start_index  index of the first candidate, sampled leaving IDLE
//             stride       index step per transfer (0 behaves as 1)
//             stop         terminate generation (goes to DONE)
//             guess_ready  consumer accepts this cycle
//             guess_valid  candidate on guess/guess_len is valid
//             guess        candidate, char 0 in [127:120], unused bytes zero
//             guess_len    candidate length in bytes
//             exhausted    every candidate up to MAX_LEN has been issued
//             busy         in SEEK or OFFER
//             issued_count completed handshakes, saturating
// ---------------------------------------------------------------------------
module candidate_generator
  import candidate_generator_pkg::*;
#(
  parameter int         MAX_LEN   = MAX_LEN_DEF,
  parameter logic [7:0] CHAR_BASE = CHAR_BASE_DEF,
  parameter int         RADIX     = RADIX_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  candidate_generator_if.master io_bus
);

  // Registered state
  state_t                  r_state;
  logic [MAX_LEN-1:0][7:0] r_digits;
  logic [7:0]              r_len;
  logic [7:0]              r_seek_cnt;
  logic                    r_exhausted;
  logic [31:0]             r_issued_count;

  // Next-state and combinational signals
  state_t                  w_state_next;
  logic [MAX_LEN-1:0][7:0] w_digits_next;
  logic [7:0]              w_len_next;
  logic [7:0]              w_seek_next;
  logic                    w_exhausted_next;
  logic [31:0]             w_count_next;
  logic                    w_valid;
  logic                    w_transfer;
  logic [2:0]              w_step;
  logic [MAX_LEN-1:0][7:0] w_odo_digits;
  logic [7:0]              w_odo_len;
  logic                    w_odo_overflow;
  logic                    w_show;
  logic [WORD_W-1:0]       w_guess;

  // SEEK walks one index per cycle; OFFER advances by the live stride.
  assign w_step = (r_state == ST_SEEK) ? 3'd1 : eff_stride(io_bus.stride);

  candidate_generator_odometer #(
    .MAX_LEN (MAX_LEN),
    .RADIX   (RADIX)
  ) u_odometer (
    .i_digits   (r_digits),
    .i_len      (r_len),
    .i_step     (w_step),
    .o_digits   (w_odo_digits),
    .o_len      (w_odo_len),
    .o_overflow (w_odo_overflow)
  );

  assign w_transfer = (r_state == ST_OFFER) && io_bus.enable && io_bus.guess_ready;

  always_comb begin
    w_state_next     = r_state;
    w_digits_next    = r_digits;
    w_len_next       = r_len;
    w_seek_next      = r_seek_cnt;
    w_exhausted_next = r_exhausted;
    w_count_next     = r_issued_count;
    w_valid          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (io_bus.enable) begin
          w_seek_next   = io_bus.start_index;
          w_digits_next = '0;
          w_len_next    = 8'd1;
          w_state_next  = (io_bus.start_index == 8'd0) ? ST_OFFER : ST_SEEK;
        end
      end

      ST_SEEK: begin
        if (io_bus.enable) begin
          w_seek_next = r_seek_cnt - 8'd1;
          if (w_odo_overflow) begin
            // Start index lies beyond the last representable candidate.
            w_exhausted_next = 1'b1;
            w_state_next     = ST_DONE;
          end else begin
            w_digits_next = w_odo_digits;
            w_len_next    = w_odo_len;
            if (r_seek_cnt == 8'd1) begin
              w_state_next = ST_OFFER;
            end
          end
        end
      end

      ST_OFFER: begin
        w_valid = io_bus.enable;
        if (w_transfer) begin
          if (r_issued_count != 32'hFFFF_FFFF) begin
            w_count_next = r_issued_count + 32'd1;
          end
          if (w_odo_overflow) begin
            // The candidate just taken was the last one.
            w_exhausted_next = 1'b1;
            w_state_next     = ST_DONE;
          end else begin
            w_digits_next = w_odo_digits;
            w_len_next    = w_odo_len;
          end
        end
      end

      default: begin
        // ST_DONE is terminal until reset.
      end
    endcase

    // stop overrides everything except the handshake count, and never flags
    // exhaustion even if the final advance would have overflowed.
    if (io_bus.stop) begin
      w_state_next     = ST_DONE;
      w_exhausted_next = r_exhausted;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_digits       <= '0;
      r_len          <= 8'd1;
      r_seek_cnt     <= 8'd0;
      r_exhausted    <= 1'b0;
      r_issued_count <= 32'd0;
    end else begin
      r_state        <= w_state_next;
      r_digits       <= w_digits_next;
      r_len          <= w_len_next;
      r_seek_cnt     <= w_seek_next;
      r_exhausted    <= w_exhausted_next;
      r_issued_count <= w_count_next;
    end
  end

  // The odometer already holds "a" while idle, but the word reads as zero
  // until generation has actually begun.
  assign w_show = (r_state != ST_IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < WORD_W / 8; gi++) begin : g_byte
      if (gi < MAX_LEN) begin : g_used
        assign w_guess[WORD_W-1-8*gi -: 8] =
          (w_show && (8'(gi) < r_len)) ? (CHAR_BASE + r_digits[gi]) : 8'h00;
      end else begin : g_unused
        assign w_guess[WORD_W-1-8*gi -: 8] = 8'h00;
      end
    end
  endgenerate

  assign io_bus.guess_valid  = w_valid;
  assign io_bus.guess        = w_guess;
  assign io_bus.guess_len    = r_len;
  assign io_bus.exhausted    = r_exhausted;
  assign io_bus.busy         = (r_state == ST_SEEK) || (r_state == ST_OFFER);
  assign io_bus.issued_count = r_issued_count;

endmodule

// File: tb/tb_candidate_generator.sv
module tb_candidate_generator;

  logic clk;
  logic rst;

  candidate_generator_if bus1 ();
  candidate_generator_if bus2 ();

  candidate_generator dut (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus1.master)
  );

  candidate_generator #(
    .MAX_LEN (2),
    .RADIX   (3)
  ) dut_small (
    .i_clock (clk),
    .i_reset (rst),
    .io_bus  (bus2.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp;
  int n_err;

  typedef struct {
    logic         en;
    logic         ready;
    logic         stop;
    logic         req_valid;
    logic [127:0] req_guess;
    logic [7:0]   req_len;
  } vec_t;

  vec_t vecs[40];
  int   nvec;

  // Pack a string left-justified into a 128-bit word.
  function automatic logic [127:0] w(input string s);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < s.len(); i++) begin
      r[127-8*i -: 8] = s[i];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input logic en, input logic ready, input logic stop,
                         input logic v, input logic [127:0] g, input logic [7:0] l);
    vecs[nvec].en        = en;
    vecs[nvec].ready     = ready;
    vecs[nvec].stop      = stop;
    vecs[nvec].req_valid = v;
    vecs[nvec].req_guess = g;
    vecs[nvec].req_len   = l;
    nvec++;
  endtask

  // One vector per cycle on the full-size instance: drive, settle, compare,
  // then let the clock edge perform whatever transfer the vector implies.
  task automatic run_table(input string tag);
    for (int i = 0; i < nvec; i++) begin
      bus1.enable      = vecs[i].en;
      bus1.guess_ready = vecs[i].ready;
      bus1.stop        = vecs[i].stop;
      #1;
      check($sformatf("%s[%0d].valid", tag, i), 128'(bus1.guess_valid), 128'(vecs[i].req_valid));
      if (vecs[i].req_valid) begin
        check($sformatf("%s[%0d].guess", tag, i), bus1.guess, vecs[i].req_guess);
        check($sformatf("%s[%0d].len", tag, i), 128'(bus1.guess_len), 128'(vecs[i].req_len));
      end
      $display("%s txn %0d: valid=%0b ready=%0b guess=%h len=%0d", tag, i,
               bus1.guess_valid, bus1.guess_ready, bus1.guess, bus1.guess_len);
      tick();
    end
    bus1.stop = 1'b0;
  endtask

  task automatic do_reset();
    bus1.enable = 1'b0; bus1.stop = 1'b0; bus1.guess_ready = 1'b0;
    bus2.enable = 1'b0; bus2.stop = 1'b0; bus2.guess_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Returns the number of cycles until guess_valid rises (bounded).
  task automatic wait_valid(input int limit, output int cycles);
    cycles = 0;
    while (!bus1.guess_valid && cycles < limit) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  string small_seq[12];
  int    cyc;

  initial begin
    n_cmp = 0;
    n_err = 0;
    bus1.start_index = 8'd0; bus1.stride = 3'd1;
    bus2.start_index = 8'd0; bus2.stride = 3'd1;
    bus1.enable = 1'b0; bus1.stop = 1'b0; bus1.guess_ready = 1'b0;
    bus2.enable = 1'b0; bus2.stop = 1'b0; bus2.guess_ready = 1'b0;
    rst = 1'b1;
    #2;

    // Reset state
    check("rst.valid", 128'(bus1.guess_valid), 128'd0);
    check("rst.guess", bus1.guess, 128'd0);
    check("rst.len", 128'(bus1.guess_len), 128'd1);
    check("rst.exhausted", 128'(bus1.exhausted), 128'd0);
    check("rst.busy", 128'(bus1.busy), 128'd0);
    check("rst.count", 128'(bus1.issued_count), 128'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 1) start 0, stride 1, always ready: a..z, aa, ab
    bus1.start_index = 8'd0; bus1.stride = 3'd1;
    bus1.enable = 1'b1; bus1.guess_ready = 1'b1;
    tick();
    nvec = 0;
    for (int i = 0; i < 26; i++) add_vec(1, 1, 0, 1, {8'(8'h61 + i), 120'd0}, 8'd1);
    add_vec(1, 1, 0, 1, {16'h6161, 112'd0}, 8'd2);
    add_vec(1, 1, 0, 1, w("ab"), 8'd2);
    run_table("seq1");
    check("seq1.count", 128'(bus1.issued_count), 128'd28);

    // 2) start 24, stride 3: 24 SEEK cycles then y, ab, ae, ah
    do_reset();
    bus1.start_index = 8'd24; bus1.stride = 3'd3;
    bus1.enable = 1'b1; bus1.guess_ready = 1'b1;
    tick();
    #1;
    check("seek.busy", 128'(bus1.busy), 128'd1);
    wait_valid(40, cyc);
    check("seek.cycles", 128'(cyc), 128'd24);
    nvec = 0;
    add_vec(1, 1, 0, 1, w("y"), 8'd1);
    add_vec(1, 1, 0, 1, w("ab"), 8'd2);
    add_vec(1, 1, 0, 1, w("ae"), 8'd2);
    add_vec(1, 1, 0, 1, w("ah"), 8'd2);
    run_table("stride3");
    check("stride3.count", 128'(bus1.issued_count), 128'd4);

    // 3) backpressure and enable pulse, stride 2
    do_reset();
    bus1.start_index = 8'd0; bus1.stride = 3'd2;
    bus1.enable = 1'b1;
    tick();
    nvec = 0;
    add_vec(1, 1, 0, 1, w("a"), 8'd1);
    add_vec(1, 0, 0, 1, w("c"), 8'd1);
    add_vec(1, 0, 0, 1, w("c"), 8'd1);
    add_vec(1, 1, 0, 1, w("c"), 8'd1);
    add_vec(0, 1, 0, 0, w("e"), 8'd1);
    add_vec(1, 1, 0, 1, w("e"), 8'd1);
    add_vec(1, 0, 0, 1, w("g"), 8'd1);
    run_table("bp");
    check("bp.count", 128'(bus1.issued_count), 128'd3);

    // 4) stop coinciding with the 5th transfer
    do_reset();
    bus1.start_index = 8'd0; bus1.stride = 3'd1;
    bus1.enable = 1'b1;
    tick();
    nvec = 0;
    add_vec(1, 1, 0, 1, w("a"), 8'd1);
    add_vec(1, 1, 0, 1, w("b"), 8'd1);
    add_vec(1, 1, 0, 1, w("c"), 8'd1);
    add_vec(1, 1, 0, 1, w("d"), 8'd1);
    add_vec(1, 1, 1, 1, w("e"), 8'd1);
    add_vec(1, 1, 0, 0, w("f"), 8'd1);
    run_table("stop");
    check("stop.count", 128'(bus1.issued_count), 128'd5);
    check("stop.exhausted", 128'(bus1.exhausted), 128'd0);
    check("stop.busy", 128'(bus1.busy), 128'd0);

    // 5) MAX_LEN=2, RADIX=3: 12 candidates then exhaustion
    do_reset();
    small_seq = '{"a", "b", "c", "aa", "ab", "ac", "ba", "bb", "bc", "ca", "cb", "cc"};
    bus2.start_index = 8'd0; bus2.stride = 3'd1;
    bus2.enable = 1'b1; bus2.guess_ready = 1'b1;
    tick();
    for (int k = 0; k < 12; k++) begin
      check($sformatf("small[%0d].valid", k), 128'(bus2.guess_valid), 128'd1);
      check($sformatf("small[%0d].guess", k), bus2.guess, w(small_seq[k]));
      check($sformatf("small[%0d].len", k), 128'(bus2.guess_len), 128'(small_seq[k].len()));
      $display("small txn %0d: guess=%h len=%0d", k, bus2.guess, bus2.guess_len);
      tick();
    end
    check("small.valid_end", 128'(bus2.guess_valid), 128'd0);
    check("small.exhausted", 128'(bus2.exhausted), 128'd1);
    check("small.busy", 128'(bus2.busy), 128'd0);
    check("small.count", 128'(bus2.issued_count), 128'd12);
    tick();
    check("small.valid_hold", 128'(bus2.guess_valid), 128'd0);

    // 6) async reset in the middle of SEEK, then restart
    do_reset();
    bus1.start_index = 8'd10; bus1.stride = 3'd1;
    bus1.enable = 1'b1; bus1.guess_ready = 1'b1;
    tick();
    tick(); tick(); tick();
    check("arst.busy_before", 128'(bus1.busy), 128'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst.busy", 128'(bus1.busy), 128'd0);
    check("arst.guess", bus1.guess, 128'd0);
    check("arst.len", 128'(bus1.guess_len), 128'd1);
    check("arst.valid", 128'(bus1.guess_valid), 128'd0);
    check("arst.count", 128'(bus1.issued_count), 128'd0);
    rst = 1'b0;
    tick();
    wait_valid(40, cyc);
    check("arst.seek_cycles", 128'(cyc), 128'd10);
    check("arst.first", bus1.guess, w("k"));
    $display("arst txn: guess=%h len=%0d", bus1.guess, bus1.guess_len);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
